// File: rtl/cmult_pkg.sv
// Shared types and constants for the Q1.15 complex multiplier.
package cmult_pkg;

  localparam int CMULT_DATA_WIDTH = 16;
  localparam int CMULT_FRAC_BITS  = 15;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] prod_t;
  typedef logic signed [32:0] acc_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

endpackage

// File: rtl/complex_mult_q15_if.sv
// Operand/result bundle for complex_mult_q15; master drives operands, slave returns results.
interface complex_mult_q15_if;
  import cmult_pkg::*;

  logic    in_valid;
  sample_t a_real;
  sample_t a_imag;
  sample_t b_real;
  sample_t b_imag;
  sample_t out_real;
  sample_t out_imag;
  logic    out_valid;

  modport master (
    output in_valid, a_real, a_imag, b_real, b_imag,
    input  out_real, out_imag, out_valid
  );

  modport slave (
    input  in_valid, a_real, a_imag, b_real, b_imag,
    output out_real, out_imag, out_valid
  );

endinterface

// File: rtl/cmult_round_sat.sv
// Combinational acc_t -> sample_t: round half up (CMULT_ROUND_EN) or floor, shift by FRAC_BITS,
// saturate. Zero latency, no flow control.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int FRAC_BITS = CMULT_FRAC_BITS
) (
  input  acc_t    acc_i,
  output sample_t res_o
);

  // One guard bit above acc_t so the rounding offset can never wrap.
  typedef logic signed [33:0] wide_t;

  localparam wide_t HI = 34'(SAT_MAX);
  localparam wide_t LO = 34'(SAT_MIN);

  wide_t biased;
  wide_t shifted;

`ifdef CMULT_ROUND_EN
  localparam wide_t HALF = 34'sd1 <<< (FRAC_BITS - 1);
  assign biased = 34'(acc_i) + HALF;
`else
  assign biased = 34'(acc_i);
`endif

  assign shifted = biased >>> FRAC_BITS;

  always_comb begin
    res_o = shifted[15:0];
    if (shifted > HI) begin
      res_o = SAT_MAX;
    end else if (shifted < LO) begin
      res_o = SAT_MIN;
    end
  end

endmodule

// File: rtl/complex_mult_q15.sv
// Pipelined Q1.15 complex multiply out = a*b; 3-cycle latency, 1 pair/cycle, no backpressure.
// Rounding mode selected by CMULT_ROUND_EN (see cmult_round_sat).
module complex_mult_q15
  import cmult_pkg::*;
#(
  parameter int DATA_WIDTH = CMULT_DATA_WIDTH,
  parameter int FRAC_BITS  = CMULT_FRAC_BITS
) (
  input logic              clk,
  input logic              reset,
  complex_mult_q15_if.slave bus
);

  if (DATA_WIDTH != $bits(sample_t)) begin : g_width_check
    $error("complex_mult_q15: DATA_WIDTH must match sample_t");
  end

  // Stage 1: operand capture
  logic    s1_vld_q;
  sample_t s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_ar_q  <= '0;
      s1_ai_q  <= '0;
      s1_br_q  <= '0;
      s1_bi_q  <= '0;
    end else begin
      s1_vld_q <= bus.in_valid;
      s1_ar_q  <= bus.a_real;
      s1_ai_q  <= bus.a_imag;
      s1_br_q  <= bus.b_real;
      s1_bi_q  <= bus.b_imag;
    end
  end

  // Stage 2: four partial products (true result always fits 32 bits signed)
  logic  s2_vld_q;
  prod_t pr_rr_d, pr_ii_d, pr_ri_d, pr_ir_d;
  prod_t pr_rr_q, pr_ii_q, pr_ri_q, pr_ir_q;

  assign pr_rr_d = prod_t'(s1_ar_q) * prod_t'(s1_br_q);
  assign pr_ii_d = prod_t'(s1_ai_q) * prod_t'(s1_bi_q);
  assign pr_ri_d = prod_t'(s1_ar_q) * prod_t'(s1_bi_q);
  assign pr_ir_d = prod_t'(s1_ai_q) * prod_t'(s1_br_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      pr_rr_q  <= '0;
      pr_ii_q  <= '0;
      pr_ri_q  <= '0;
      pr_ir_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      pr_rr_q  <= pr_rr_d;
      pr_ii_q  <= pr_ii_d;
      pr_ri_q  <= pr_ri_d;
      pr_ir_q  <= pr_ir_d;
    end
  end

  // Stage 3: combine, scale, saturate
  acc_t    re_acc, im_acc;
  sample_t out_re_d, out_im_d;
  sample_t out_re_q, out_im_q;
  logic    out_vld_q;

  assign re_acc = acc_t'(pr_rr_q) - acc_t'(pr_ii_q);
  assign im_acc = acc_t'(pr_ri_q) + acc_t'(pr_ir_q);

  cmult_round_sat #(.FRAC_BITS(FRAC_BITS)) u_rs_re (
    .acc_i (re_acc),
    .res_o (out_re_d)
  );

  cmult_round_sat #(.FRAC_BITS(FRAC_BITS)) u_rs_im (
    .acc_i (im_acc),
    .res_o (out_im_d)
  );

  // Results only move on valid beats so bubbles leave the last value visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
    end else begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_re_q <= out_re_d;
        out_im_q <= out_im_d;
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_real  = out_re_q;
  assign bus.out_imag  = out_im_q;

endmodule

// File: tb/tb_complex_mult_q15.sv
// Randomised + directed bench for complex_mult_q15 against an arithmetic reference model.
module tb_complex_mult_q15;
  import cmult_pkg::*;

  localparam int LAT = 3;

  logic clk;
  logic reset;
  complex_mult_q15_if vif();

  complex_mult_q15 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit vld;
    int re;
    int im;
  } exp_t;

  exp_t pipe[$];
  int   last_re = 0;
  int   last_im = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact product sum, optional +0.5 LSB, floor divide by 2^15, clamp.
  function automatic int ref_scale(input longint acc);
    longint v;
`ifdef CMULT_ROUND_EN
    v = (acc + 64'sd16384) >>> 15;
`else
    v = acc >>> 15;
`endif
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  function automatic int rnd_val();
    int sel;
    sel = int'($urandom_range(0, 15));
    case (sel)
      0:       return -32768;
      1:       return 32767;
      2:       return 0;
      3:       return -1;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Present one cycle of input, advance one edge, then compare outputs to the model.
  task automatic drive(input bit v, input int ar, input int ai, input int br, input int bi);
    exp_t e;
    exp_t cur;
    vif.in_valid = v;
    vif.a_real   = sample_t'(ar);
    vif.a_imag   = sample_t'(ai);
    vif.b_real   = sample_t'(br);
    vif.b_imag   = sample_t'(bi);
    @(posedge clk);
    e.vld = v;
    e.re  = ref_scale(longint'(ar) * br - longint'(ai) * bi);
    e.im  = ref_scale(longint'(ar) * bi + longint'(ai) * br);
    pipe.push_back(e);
    if (pipe.size() > LAT) void'(pipe.pop_front());
    #1;
    cur.vld = 1'b0;
    cur.re  = 0;
    cur.im  = 0;
    if (pipe.size() == LAT) cur = pipe[0];
    if (cur.vld) begin
      last_re = cur.re;
      last_im = cur.im;
    end
    chk("out_valid", 32'(vif.out_valid), 32'(cur.vld));
    chk("out_real",  32'(vif.out_real),  last_re);
    chk("out_imag",  32'(vif.out_imag),  last_im);
  endtask

  // One vector followed by two bubbles; after the third edge its result must be on the outputs.
  task automatic directed(input string tag, input int ar, input int ai, input int br,
                          input int bi, input int er, input int ei);
    drive(1'b1, ar, ai, br, bi);
    drive(1'b0, 0, 0, 0, 0);
    drive(1'b0, 0, 0, 0, 0);
    chk({tag, "_vld"}, 32'(vif.out_valid), 1);
    chk({tag, "_re"},  32'(vif.out_real),  er);
    chk({tag, "_im"},  32'(vif.out_imag),  ei);
  endtask

  initial begin
    reset        = 1'b1;
    vif.in_valid = 1'b0;
    vif.a_real   = '0;
    vif.a_imag   = '0;
    vif.b_real   = '0;
    vif.b_imag   = '0;
    #1;
    chk("rst_vld", 32'(vif.out_valid), 0);
    chk("rst_re",  32'(vif.out_real),  0);
    chk("rst_im",  32'(vif.out_imag),  0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    directed("unit_half",  16384, 0, 16384, 0, 8192, 0);
    directed("j_times_j",  0, 16384, 0, 16384, -8192, 0);
    directed("conj_pair",  16384, 16384, 16384, -16384, 16384, 0);
    directed("sat_minmin", -32768, 0, -32768, 0, 32767, 0);
    directed("max_sq",     32767, 0, 32767, 0, 32766, 0);
`ifdef CMULT_ROUND_EN
    directed("half_pos",   1, 0, 16384, 0, 1, 0);
    directed("half_neg",   -1, 0, 16384, 0, 0, 0);
`else
    directed("half_pos",   1, 0, 16384, 0, 0, 0);
    directed("half_neg",   -1, 0, 16384, 0, -1, 0);
`endif
    directed("imag_sat",   -32768, -32768, -32768, -32768, 0, 32767);

    for (int n = 0; n < 1000; n++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      drive(v, rnd_val(), rnd_val(), rnd_val(), rnd_val());
    end

    // Mid-stream reset: three valid vectors in flight must be dropped.
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, rnd_val(), rnd_val(), rnd_val(), rnd_val());
    end
    reset = 1'b1;
    #1;
    chk("midrst_vld", 32'(vif.out_valid), 0);
    chk("midrst_re",  32'(vif.out_real),  0);
    chk("midrst_im",  32'(vif.out_imag),  0);
    pipe.delete();
    last_re = 0;
    last_im = 0;
    vif.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 0, 0, 0, 0);
    end
    directed("post_rst", 16384, 0, 16384, 0, 8192, 0);
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, rnd_val(), rnd_val(), rnd_val(), rnd_val());
    end
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
